// File: rtl/noc_pkt_pkg.sv
// Shared NoC flit field helpers, used by both the packetizer and the depacketizer.
// Every flit starts MSB-first with [valid][head][tail][vc]; head flits then carry [dest].
package noc_pkt_pkg;

  function automatic int valid_bit(input int width_flit);
    return width_flit - 1;
  endfunction

  function automatic int head_bit(input int width_flit);
    return width_flit - 2;
  endfunction

  function automatic int tail_bit(input int width_flit);
    return width_flit - 3;
  endfunction

  function automatic int vc_lsb(input int width_flit, input int vc_w);
    return width_flit - 3 - vc_w;
  endfunction

  function automatic int dest_lsb(input int width_flit, input int vc_w, input int addr_w);
    return width_flit - 3 - vc_w - addr_w;
  endfunction

  function automatic int payload_width(input int width_flit, input int vc_w, input int addr_w,
                                       input bit is_head);
    return is_head ? (width_flit - 3 - vc_w - addr_w) : (width_flit - 3 - vc_w);
  endfunction

  // Fewest flits whose payload fields can hold the user data.
  function automatic int num_flits(input int dh, input int db, input int width_data);
    int r;
    r = 4;
    for (int n = 4; n >= 1; n--) begin
      if (dh + (n - 1) * db >= width_data) r = n;
    end
    return r;
  endfunction

endpackage

// File: rtl/pkt_fifo2.sv
// Two-entry registered FIFO with ready/valid on both sides.
// wr_ready comes straight from the count register, so there is no path from rd_ready.
module pkt_fifo2 #(
  parameter int WIDTH = 36
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             wr_valid,
  output logic             wr_ready,
  output logic [WIDTH-1:0] rd_data,
  output logic             rd_valid,
  input  logic             rd_ready
);

  logic [1:0]       count;
  logic             wr_ptr;
  logic             rd_ptr;
  logic [WIDTH-1:0] entry [2];
  logic             push;
  logic             pop;

  assign wr_ready = (count != 2'd2);
  assign rd_valid = (count != 2'd0);
  assign rd_data  = entry[rd_ptr];
  assign push     = wr_valid & wr_ready;
  assign pop      = rd_valid & rd_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count    <= 2'd0;
      wr_ptr   <= 1'b0;
      rd_ptr   <= 1'b0;
      entry[0] <= '0;
      entry[1] <= '0;
    end else begin
      if (push) begin
        entry[wr_ptr] <= wr_data;
        wr_ptr        <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/packetizer.sv
// Builds one 4-flit NoC packet per accepted user word and queues it in a 2-entry buffer.
// Data is left-justified into a full payload frame, then sliced head, b1, b2, tail.
module packetizer
  import noc_pkt_pkg::*;
#(
  parameter int WIDTH_PKT        = 36,
  parameter int WIDTH_DATA       = 12,
  parameter int VC_ADDRESS_WIDTH = 1,
  parameter int ADDRESS_WIDTH    = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [WIDTH_DATA-1:0]       i_data_in,
  input  logic [ADDRESS_WIDTH-1:0]    i_dest_in,
  input  logic [VC_ADDRESS_WIDTH-1:0] i_vc_in,
  input  logic                        i_valid_in,
  output logic                        i_ready_out,
  output logic [WIDTH_PKT-1:0]        o_packet_out,
  output logic                        o_valid_out,
  input  logic                        o_ready_in
);

  localparam int WIDTH_FLIT     = WIDTH_PKT / 4;
  localparam int DH             = payload_width(WIDTH_FLIT, VC_ADDRESS_WIDTH, ADDRESS_WIDTH, 1'b1);
  localparam int DB             = payload_width(WIDTH_FLIT, VC_ADDRESS_WIDTH, ADDRESS_WIDTH, 1'b0);
  localparam int WIDTH_DATA_IDL = DH + 3 * DB;
  localparam int NUM_FLITS      = num_flits(DH, DB, WIDTH_DATA);
  localparam int VALID_B        = valid_bit(WIDTH_FLIT);
  localparam int HEAD_B         = head_bit(WIDTH_FLIT);
  localparam int TAIL_B         = tail_bit(WIDTH_FLIT);
  localparam int VC_LSB         = vc_lsb(WIDTH_FLIT, VC_ADDRESS_WIDTH);
  localparam int DEST_LSB       = dest_lsb(WIDTH_FLIT, VC_ADDRESS_WIDTH, ADDRESS_WIDTH);

  if (WIDTH_DATA > WIDTH_DATA_IDL) begin : g_width_check
    $error("packetizer: WIDTH_DATA exceeds the packet payload capacity");
  end

  logic [WIDTH_DATA_IDL-1:0] full_data;
  logic [WIDTH_PKT-1:0]      packet_next;

  // Trailing EXTRA_BITS of the frame stay zero.
  always_comb begin
    full_data = '0;
    full_data[WIDTH_DATA_IDL-1 -: WIDTH_DATA] = i_data_in;
  end

  for (genvar k = 0; k < 4; k++) begin : g_flit
    logic [WIDTH_FLIT-1:0] flit;
    if (k >= NUM_FLITS) begin : g_idle
      assign flit = '0;
    end else if (k == 0) begin : g_head
      always_comb begin
        flit = '0;
        flit[VALID_B] = 1'b1;
        flit[HEAD_B]  = 1'b1;
        flit[TAIL_B]  = (NUM_FLITS == 1);
        flit[VC_LSB +: VC_ADDRESS_WIDTH] = i_vc_in;
        flit[DEST_LSB +: ADDRESS_WIDTH]  = i_dest_in;
        flit[DH-1:0] = full_data[WIDTH_DATA_IDL-1 -: DH];
      end
    end else begin : g_body
      always_comb begin
        flit = '0;
        flit[VALID_B] = 1'b1;
        flit[HEAD_B]  = 1'b0;
        flit[TAIL_B]  = (k == NUM_FLITS - 1);
        flit[VC_LSB +: VC_ADDRESS_WIDTH] = i_vc_in;
        flit[DB-1:0] = full_data[WIDTH_DATA_IDL-1-DH-(k-1)*DB -: DB];
      end
    end
  end

  assign packet_next = {g_flit[0].flit, g_flit[1].flit, g_flit[2].flit, g_flit[3].flit};

  pkt_fifo2 #(
    .WIDTH(WIDTH_PKT)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .wr_data  (packet_next),
    .wr_valid (i_valid_in),
    .wr_ready (i_ready_out),
    .rd_data  (o_packet_out),
    .rd_valid (o_valid_out),
    .rd_ready (o_ready_in)
  );

endmodule
